// File: rtl/fcvt_sd_ctrl.sv
// fcvt_sd_ctrl: multi-cycle FCVT.S.D / FCVT.D.S sequencer (unpack, round, pack).
// Define FCVT_SD_FTZ_EN to flush single-precision subnormals to signed zero.
module fcvt_sd_ctrl #(
    parameter int BUS_WIDTH    = 64,
    parameter int LATENCY_HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [2:0]           req_rm,
    input  logic [2:0]           frm,
    input  logic [BUS_WIDTH-1:0] req_src,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BUS_WIDTH-1:0] resp_result,
    output logic [4:0]           resp_fflags,
    output logic                 resp_illegal
);
    localparam logic [63:0] QNAN_D = 64'h7FF8000000000000;
    localparam logic [31:0] QNAN_S = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, UNPACK, ROUND, PACK, DONE} state_t;
    state_t state, state_next;

    function automatic logic rnd_inc(input logic [2:0] rm, input logic sgn,
                                     input logic lsb, input logic g, input logic st);
        case (rm)
            3'd0:    rnd_inc = g & (st | lsb);
            3'd2:    rnd_inc = sgn & (g | st);
            3'd3:    rnd_inc = ~sgn & (g | st);
            3'd4:    rnd_inc = g;
            default: rnd_inc = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ovf_res(input logic [2:0] rm, input logic sgn);
        logic to_inf;
        to_inf  = (rm == 3'd0) || (rm == 3'd4) || ((rm == 3'd2) && sgn) || ((rm == 3'd3) && !sgn);
        ovf_res = to_inf ? {sgn, 31'h7F800000} : {sgn, 31'h7F7FFFFF};
    endfunction

    // Single subnormal -> normal double: move the leading one to the hidden position.
    function automatic logic [63:0] sd_norm_sub(input logic sgn, input logic [22:0] sf);
        logic [4:0]  p;
        logic [22:0] fn;
        p = 5'd0;
        for (int i = 0; i < 23; i++) if (sf[i]) p = 5'(i);
        fn = sf << (5'd23 - p);
        sd_norm_sub = {sgn, 11'd874 + {6'd0, p}, fn, 29'd0};
    endfunction

    logic [2:0]  rm_eff;
    logic [63:0] src_p0;
    logic        op_p0, ill_p0;
    logic [2:0]  rm_p0;

    assign rm_eff = (req_rm == 3'd7) ? frm : req_rm;

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            src_p0 <= req_src;
            op_p0  <= req_op;
            rm_p0  <= rm_eff;
            ill_p0 <= (rm_eff == 3'd5) || (rm_eff == 3'd6);
        end
    end

    // UNPACK: classify, resolve special/S->D results, set up the D->S shift
    logic [10:0]        de;
    logic [51:0]        df;
    logic [7:0]         se;
    logic [22:0]        sf;
    logic signed [12:0] es_u, sh_s;
    logic [5:0]         sh_u;
    logic               byp_u;
    logic [63:0]        byp_res_u;
    logic [4:0]         byp_flg_u;

    always_comb begin
        de        = src_p0[62:52];
        df        = src_p0[51:0];
        se        = src_p0[30:23];
        sf        = src_p0[22:0];
        es_u      = $signed({2'b00, de}) - 13'sd896;
        sh_s      = 13'sd30 - es_u;
        if (es_u > 13'sd0)       sh_u = 6'd29;
        else if (sh_s > 13'sd60) sh_u = 6'd60;
        else                     sh_u = sh_s[5:0];
        byp_u     = 1'b1;
        byp_res_u = 64'h0;
        byp_flg_u = 5'h0;
        if (op_p0) begin
            if (!(&src_p0[63:32])) begin
                byp_res_u = QNAN_D;
            end else if (se == 8'hFF) begin
                byp_res_u = (sf == '0) ? {src_p0[31], 11'h7FF, 52'd0} : QNAN_D;
                byp_flg_u = {(sf != '0) && !sf[22], 4'd0};
            end else if (se == 8'h00) begin
`ifdef FCVT_SD_FTZ_EN
                byp_res_u = {src_p0[31], 63'd0};
`else
                byp_res_u = (sf == '0) ? {src_p0[31], 63'd0} : sd_norm_sub(src_p0[31], sf);
`endif
            end else begin
                byp_res_u = {src_p0[31], {3'd0, se} + 11'd896, sf, 29'd0};
            end
        end else if (de == 11'h7FF) begin
            byp_res_u = (df == '0) ? {32'hFFFFFFFF, src_p0[63], 31'h7F800000} : {32'hFFFFFFFF, QNAN_S};
            byp_flg_u = {(df != '0) && !df[51], 4'd0};
        end else if (de == 11'h000 && df == '0) begin
            byp_res_u = {32'hFFFFFFFF, src_p0[63], 31'd0};
        end else begin
            byp_u = 1'b0;
        end
    end

    logic               sgn_p1, byp_p1;
    logic [52:0]        m_p1;
    logic signed [12:0] es_p1;
    logic [5:0]         sh_p1;
    logic [63:0]        byp_res_p1;
    logic [4:0]         byp_flg_p1;

    always_ff @(posedge clk) begin
        if (state == UNPACK) begin
            sgn_p1     <= src_p0[63];
            m_p1       <= {de != 11'h000, df};
            es_p1      <= es_u;
            sh_p1      <= sh_u;
            byp_p1     <= byp_u;
            byp_res_p1 <= byp_res_u;
            byp_flg_p1 <= byp_flg_u;
        end
    end

    // ROUND: align to 24 bits (denormalising if needed) and apply the rounding increment
    logic [87:0] wide_r;
    logic [23:0] kept_r;
    logic        g_r, st_r, carry_u;
    logic [24:0] mant_r;

    always_comb begin
        wide_r  = 88'({m_p1, 64'd0} >> sh_p1);
        kept_r  = wide_r[87:64];
        g_r     = wide_r[63];
        st_r    = |wide_r[62:0];
        mant_r  = {1'b0, kept_r} + {24'd0, rnd_inc(rm_p0, sgn_p1, kept_r[0], g_r, st_r)};
        // Tininess after rounding: would 24-bit rounding with unbounded exponent reach 2^-126?
        carry_u = (&m_p1[52:29]) && rnd_inc(rm_p0, sgn_p1, m_p1[29], m_p1[28], |m_p1[27:0]);
    end

    logic               sgn_p2, nx_p2, tiny_p2, byp_p2;
    logic [24:0]        mant_p2;
    logic signed [12:0] es_p2;
    logic [63:0]        byp_res_p2;
    logic [4:0]         byp_flg_p2;

    always_ff @(posedge clk) begin
        if (state == ROUND) begin
            sgn_p2     <= sgn_p1;
            nx_p2      <= g_r | st_r;
            tiny_p2    <= (es_p1 < 13'sd0) || ((es_p1 == 13'sd0) && !carry_u);
            mant_p2    <= mant_r;
            es_p2      <= es_p1;
            byp_p2     <= byp_p1;
            byp_res_p2 <= byp_res_p1;
            byp_flg_p2 <= byp_flg_p1;
        end
    end

    // PACK: exponent adjust, overflow/underflow resolution, NaN-boxing
    logic signed [12:0] e_out;
    logic [31:0]        ds_res;
    logic [4:0]         ds_flg;

    always_comb begin
        e_out  = es_p2 + $signed({12'd0, mant_p2[24]});
        ds_res = 32'h0;
        ds_flg = 5'h0;
        if (es_p2 > 13'sd0) begin
            if (e_out >= 13'sd255) begin
                ds_res = ovf_res(rm_p0, sgn_p2);
                ds_flg = 5'b00101;
            end else begin
                ds_res = {sgn_p2, e_out[7:0], mant_p2[24] ? 23'd0 : mant_p2[22:0]};
                ds_flg = {4'd0, nx_p2};
            end
        end else begin
`ifdef FCVT_SD_FTZ_EN
            if (!mant_p2[23]) begin
                ds_res = {sgn_p2, 31'd0};
                ds_flg = 5'b00011;
            end else begin
                ds_res = {sgn_p2, 7'd0, mant_p2[23:0]};
                ds_flg = {3'd0, tiny_p2 && nx_p2, nx_p2};
            end
`else
            ds_res = {sgn_p2, 7'd0, mant_p2[23:0]};
            ds_flg = {3'd0, tiny_p2 && nx_p2, nx_p2};
`endif
        end
    end

    logic [63:0] res_p3;
    logic [4:0]  flg_p3;

    always_ff @(posedge clk) begin
        if (state == PACK) begin
            res_p3 <= ill_p0 ? 64'h0 : (byp_p2 ? byp_res_p2 : {32'hFFFFFFFF, ds_res});
            flg_p3 <= ill_p0 ? 5'h0  : (byp_p2 ? byp_flg_p2 : ds_flg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = UNPACK;
            end
            UNPACK:  state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    if (resp_valid && (resp_ready || LATENCY_HOLD == 0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response register: loaded once on entering DONE, held until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_result  <= '0;
            resp_fflags  <= 5'h0;
            resp_illegal <= 1'b0;
        end else if (state == DONE && !resp_valid) begin
            resp_valid   <= 1'b1;
            resp_result  <= res_p3;
            resp_fflags  <= flg_p3;
            resp_illegal <= ill_p0;
        end else if (resp_valid && (resp_ready || LATENCY_HOLD == 0)) begin
            resp_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fcvt_sd_ctrl.sv
// Directed, table-driven bench for fcvt_sd_ctrl with backpressure and mid-flight reset sequences.
module tb_fcvt_sd_ctrl;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4, DYN = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [2:0]  req_rm;
    logic [2:0]  frm;
    logic [63:0] req_src;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic [4:0]  resp_fflags;
    logic        resp_illegal;

    always #5 clk = ~clk;

    fcvt_sd_ctrl #(.BUS_WIDTH(64), .LATENCY_HOLD(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rm(req_rm), .frm(frm), .req_src(req_src),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_fflags(resp_fflags), .resp_illegal(resp_illegal)
    );

    typedef struct {
        logic        op;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic [63:0] src;
        logic [63:0] res;
        logic [4:0]  flg;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic op, input logic [2:0] rm, input logic [2:0] f,
                       input logic [63:0] src, input logic [63:0] res,
                       input logic [4:0] flg, input logic ill);
        vec_t v;
        v = '{op, rm, f, src, res, flg, ill};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic op, input logic [2:0] rm,
                         input logic [2:0] f, input logic [63:0] src);
        @(negedge clk);
        chk({nm, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rm    = rm;
        frm       = f;
        req_src   = src;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int i);
        int    lat;
        string nm;
        nm = $sformatf("v%0d", i);
        issue(nm, vecs[i].op, vecs[i].rm, vecs[i].frm, vecs[i].src);
        wait_resp(lat);
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_result"},  resp_result, vecs[i].res);
        chk({nm, "_fflags"},  {59'd0, resp_fflags}, {59'd0, vecs[i].flg});
        chk({nm, "_illegal"}, {63'd0, resp_illegal}, {63'd0, vecs[i].ill});
        @(posedge clk); #1;
        chk({nm, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_rm = RNE; frm = RNE;
        req_src = 64'h0; resp_ready = 1'b1;

        // op, rm, frm, src, expected result, expected fflags, expected illegal
        add(0, RNE, 0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 5'h00, 0);
        add(0, RNE, 0, 64'h3FF0000010000000, 64'hFFFFFFFF3F800000, 5'h01, 0);
        add(0, RUP, 0, 64'h3FF0000010000000, 64'hFFFFFFFF3F800001, 5'h01, 0);
        add(0, RMM, 0, 64'h3FF0000010000000, 64'hFFFFFFFF3F800001, 5'h01, 0);
        add(0, DYN, RUP, 64'h3FF0000010000000, 64'hFFFFFFFF3F800001, 5'h01, 0);
        add(0, RTZ, 0, 64'h47F0000000000000, 64'hFFFFFFFF7F7FFFFF, 5'h05, 0);
        add(0, RNE, 0, 64'h47F0000000000000, 64'hFFFFFFFF7F800000, 5'h05, 0);
        add(0, RDN, 0, 64'h47F0000000000000, 64'hFFFFFFFF7F7FFFFF, 5'h05, 0);
        add(0, RUP, 0, 64'hC7F0000000000000, 64'hFFFFFFFFFF7FFFFF, 5'h05, 0);
        add(0, RDN, 0, 64'hC7F0000000000000, 64'hFFFFFFFFFF800000, 5'h05, 0);
        add(0, RNE, 0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 5'h10, 0);
        add(0, RNE, 0, 64'h7FF8000000000000, 64'hFFFFFFFF7FC00000, 5'h00, 0);
        add(0, 3'd5, 0, 64'h7FF0000000000001, 64'h0000000000000000, 5'h00, 1);
        add(0, RNE, 0, 64'hC000000000000000, 64'hFFFFFFFFC0000000, 5'h00, 0);
        add(0, RNE, 0, 64'h8000000000000000, 64'hFFFFFFFF80000000, 5'h00, 0);
        add(0, RNE, 0, 64'h7FF0000000000000, 64'hFFFFFFFF7F800000, 5'h00, 0);
        add(0, RNE, 0, 64'h3FFFFFFFF0000000, 64'hFFFFFFFF40000000, 5'h01, 0);
        add(0, RNE, 0, 64'h36A0000000000000, 64'hFFFFFFFF00000001, 5'h00, 0);
        add(0, RNE, 0, 64'h3690000000000000, 64'hFFFFFFFF00000000, 5'h03, 0);
        add(0, RUP, 0, 64'h3690000000000000, 64'hFFFFFFFF00000001, 5'h03, 0);
        add(0, RNE, 0, 64'h0000000000000001, 64'hFFFFFFFF00000000, 5'h03, 0);
        add(0, RDN, 0, 64'h8000000000000001, 64'hFFFFFFFF80000001, 5'h03, 0);
        add(0, RNE, 0, 64'h380FFFFFF0000000, 64'hFFFFFFFF00800000, 5'h01, 0);
        add(1, RNE, 0, 64'hFFFFFFFF00000001, 64'h36A0000000000000, 5'h00, 0);
        add(1, RNE, 0, 64'h0000000040000000, 64'h7FF8000000000000, 5'h00, 0);
        add(1, DYN, 3'd6, 64'hFFFFFFFF3F800000, 64'h0000000000000000, 5'h00, 1);
        add(1, RTZ, 0, 64'hFFFFFFFF3F800000, 64'h3FF0000000000000, 5'h00, 0);
        add(1, RNE, 0, 64'hFFFFFFFF7F800001, 64'h7FF8000000000000, 5'h10, 0);
        add(1, RNE, 0, 64'hFFFFFFFFFF800000, 64'hFFF0000000000000, 5'h00, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid",   {63'd0, resp_valid},   64'd0);
        chk("rst_resp_result",  resp_result,           64'd0);
        chk("rst_resp_fflags",  {59'd0, resp_fflags},  64'd0);
        chk("rst_resp_illegal", {63'd0, resp_illegal}, 64'd0);
        chk("rst_req_ready",    {63'd0, req_ready},    64'd1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Backpressure: result must hold while the consumer stalls
        resp_ready = 1'b0;
        issue("bp", 1'b0, RUP, 3'd0, 64'h3FF0000010000000);
        wait_resp(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_result_c%0d", c), resp_result, 64'hFFFFFFFF3F800001);
            chk($sformatf("bp_fflags_c%0d", c), {59'd0, resp_fflags}, 64'h01);
            chk($sformatf("bp_valid_c%0d", c),  {63'd0, resp_valid}, 64'd1);
            chk($sformatf("bp_ready_c%0d", c),  {63'd0, req_ready},  64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        chk("bp_result_release", resp_result, 64'hFFFFFFFF3F800001);
        @(posedge clk); #1;
        chk("bp_valid_drop", {63'd0, resp_valid}, 64'd0);

        // Reset while the operation sits in ROUND: it must vanish without a response
        issue("rst_mid", 1'b0, RNE, 3'd0, 64'h47F0000000000000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_mid_req_ready",  {63'd0, req_ready},  64'd1);
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rst_mid_no_resp", 64'(seen), 64'd0);

        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
